mnist_frame_controller: RTL and testbench
=========================================

# mnist_frame_controller

Sequencer between the 7-bit host input bus and the MNIST inference datapath. It frames 14×14 binary images as 28 beats (14 rows × 2 half-rows of 7 pixels), writes each beat into the image buffer, and pulses the classifier start. It then waits for the classifier result with a timeout and holds the digit result for the host until it is acknowledged or the next frame begins.

## Interface
- TIMEOUT_CYCLES, 1023: classifier wait limit in cycles (≥1).
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_valid  in  1  beat present on data_in.
- host_sof  in  1  start-of-frame; qualifies the first beat of a frame.
- data_in  in  7  pixel beat; bit 6 = leftmost pixel of the half-row.
- host_ready  out  1  controller accepts beats.
- result_ack  in  1  host consumed result.
- pix_wr_en  out  1  image-buffer write strobe (registered).
- pix_addr  out  5  beat index 0..27; row = pix_addr[4:1], half = pix_addr[0] (0 = left).
- pix_data  out  7  registered copy of the accepted data_in.
- cls_start  out  1  one-cycle classifier start pulse.
- cls_done  in  1  classifier finished; cls_digit is valid the same cycle.
- cls_digit  in  4  classified digit 0..9.
- result_valid  out  1  result held.
- result  out  4  latched digit.
- frame_error  out  1  one-cycle pulse on restart-mid-frame or timeout.
- busy  out  1  high in LOAD, START, WAIT.

## Operation
- Accept = host_valid & host_ready, sampled on the rising edge.
- host_ready is combinational from state: 1 in IDLE, LOAD and DONE; 0 in START and WAIT.
- IDLE:
  - An accepted beat with host_sof=1 writes beat 0 and goes to LOAD with beat_cnt=1.
  - An accepted beat with host_sof=0 is dropped silently.
- LOAD:
  - An accepted beat with host_sof=0 writes at beat_cnt, then increments beat_cnt.
  - An accepted beat with host_sof=1 restarts the frame: frame_error pulses, the beat is written as beat 0, and beat_cnt=1.
  - Acceptance of beat 27 (beat_cnt==27, host_sof=0) moves to START.
- START: one-cycle gap state; it registers cls_start=1 and goes to WAIT.
- WAIT:
  - cls_done latches cls_digit into result, sets result_valid, and goes to DONE.
  - Otherwise the wait timer increments. When the timer equals TIMEOUT_CYCLES, frame_error pulses, result_valid stays 0, and the controller goes to IDLE.
  - cls_done outside WAIT is ignored.
- DONE:
  - result_valid=1 and result is held.
  - result_ack clears result_valid and goes to IDLE.
  - An accepted sof beat clears result_valid, writes beat 0 and goes to LOAD. If it coincides with result_ack, the sof beat takes priority and the ack is absorbed.
  - Non-sof beats are dropped.
- A digit outside 0..9 is latched unchanged; the controller does not check range.

## Timing
- Reset values:
  - State IDLE; beat_cnt and timer 0.
  - pix_wr_en 0, pix_addr 0, pix_data 0, cls_start 0.
  - result_valid 0, result 0, frame_error 0, busy 0.
  - host_ready is 1 immediately, since IDLE is entered combinationally from reset.
- Write latency: pix_wr_en, pix_addr and pix_data appear in the cycle after the accepting edge, for exactly one cycle per accepted beat.
- Last beat accepted at edge E0:
  - After E0: write of addr 27 is visible; state START.
  - After E1: cls_start=1; state WAIT.
  - After E2: cls_start=0.
  - The final write always precedes cls_start by one cycle.
- Full frame at 100% valid: 28 accepts, then cls_start 2 cycles after the last accept.
- Timer:
  - Clears on WAIT entry.
  - Timeout after exactly TIMEOUT_CYCLES WAIT cycles without cls_done.
  - cls_done in the timeout cycle wins: the result is latched and no error is raised.
- frame_error and cls_start are registered single-cycle pulses.
- busy and host_ready are decoded from state.
- Reset mid-operation aborts any frame or wait immediately; a partial buffer is not cleared.

## Structure
- Shared package mnist_pkg:
  - Constants IMG_ROWS=14, BEATS_PER_ROW=2, BEATS_PER_FRAME=28, BEAT_W=7, DIGIT_W=4.
  - State enum {IDLE, LOAD, START, WAIT, DONE}.
- Sub-module mnist_wait_timer: parameterized up-counter with clear/enable/expired, width $clog2(TIMEOUT_CYCLES+1).
- Remaining logic, a single FSM with a beat counter, lives in the top module.

## Test plan
- Reset then 28 valid beats, first with sof, data = beat index → pix_addr 0..27 each one cycle after accept; cls_start single pulse exactly 2 cycles after the 28th accept; busy=1 throughout.
- WAIT with cls_done=1, cls_digit=7 after 5 cycles → result=7, result_valid=1 until result_ack, then IDLE with host_ready=1.
- sof beat at beat_cnt=10 → frame_error pulse, pix_addr=0 for that beat, the next beat writes addr 1; the frame completes after 27 further beats.
- TIMEOUT_CYCLES=8 with no cls_done → frame_error pulse after 8 WAIT cycles, result_valid=0, state IDLE; then cls_done in the timeout cycle in a rerun → result latched, no error.
- In DONE, sof beat plus result_ack in the same cycle → LOAD, write addr 0, result_valid=0.
- Non-sof beats in IDLE and DONE → no pix_wr_en; reset_n low during WAIT → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants and state type for the MNIST frame path
// Image geometry: 14 rows x 2 half-rows of 7 pixels = 28 beats per frame.
package mnist_pkg;

  localparam int IMG_ROWS        = 14;
  localparam int BEATS_PER_ROW   = 2;
  localparam int BEATS_PER_FRAME = IMG_ROWS * BEATS_PER_ROW;
  localparam int BEAT_W          = 7;
  localparam int DIGIT_W         = 4;
  localparam int ADDR_W          = 5;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mnist_wait_timer.sv
// rtl/mnist_wait_timer.sv - classifier wait up-counter with clear/enable/expired
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous return to zero (has priority over enable)
//   enable       : count one cycle
//   expired      : combinational; high in the enabled cycle that completes LIMIT counts
module mnist_wait_timer #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Flag the cycle in which the counter would reach LIMIT, so the owner acts
  // at the end of exactly LIMIT enabled cycles.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mnist_frame_controller.sv
// rtl/mnist_frame_controller.sv - frames host beats into the image buffer and sequences the classifier
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   host_valid/host_sof/data_in, host_ready : host beat stream (sof marks beat 0)
//   pix_wr_en/pix_addr/pix_data : registered image-buffer write, one cycle per accepted beat
//   cls_start, cls_done/cls_digit : classifier start pulse and completion
//   result_valid/result/result_ack : held digit for the host
//   frame_error               : pulse on restart mid-frame or classifier timeout
//   busy                      : high in LOAD, START, WAIT
module mnist_frame_controller
  import mnist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               host_valid,
  input  logic               host_sof,
  input  logic [BEAT_W-1:0]  data_in,
  output logic               host_ready,
  input  logic               result_ack,
  output logic               pix_wr_en,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [BEAT_W-1:0]  pix_data,
  output logic               cls_start,
  input  logic               cls_done,
  input  logic [DIGIT_W-1:0] cls_digit,
  output logic               result_valid,
  output logic [DIGIT_W-1:0] result,
  output logic               frame_error,
  output logic               busy
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic                pix_wr_en_nxt;
  logic [ADDR_W-1:0]   pix_addr_nxt;
  logic [BEAT_W-1:0]   pix_data_nxt;
  logic                cls_start_nxt;
  logic                result_valid_nxt;
  logic [DIGIT_W-1:0]  result_nxt;
  logic                frame_error_nxt;

  logic                accept;
  logic                timer_clear;
  logic                timer_enable;
  logic                timer_expired;

  assign host_ready = (state == IDLE) || (state == LOAD) || (state == DONE);
  assign busy       = (state == LOAD) || (state == START) || (state == WAIT);
  assign accept     = host_valid && host_ready;

  // Holding the timer clear outside WAIT makes every WAIT entry start from zero;
  // a cls_done cycle is not counted so completion always beats the timeout.
  assign timer_clear  = (state != WAIT);
  assign timer_enable = (state == WAIT) && !cls_done;

  mnist_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_nxt        = state;
    beat_cnt_nxt     = beat_cnt;
    pix_wr_en_nxt    = 1'b0;
    pix_addr_nxt     = pix_addr;
    pix_data_nxt     = pix_data;
    cls_start_nxt    = 1'b0;
    result_valid_nxt = result_valid;
    result_nxt       = result;
    frame_error_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (accept && host_sof) begin
          pix_wr_en_nxt = 1'b1;
          pix_addr_nxt  = '0;
          pix_data_nxt  = data_in;
          beat_cnt_nxt  = ADDR_W'(1);
          state_nxt     = LOAD;
        end
      end

      LOAD: begin
        if (accept) begin
          pix_wr_en_nxt = 1'b1;
          pix_data_nxt  = data_in;
          if (host_sof) begin
            // New frame before the old one finished: restart at beat 0.
            frame_error_nxt = 1'b1;
            pix_addr_nxt    = '0;
            beat_cnt_nxt    = ADDR_W'(1);
          end else begin
            pix_addr_nxt = beat_cnt;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt_nxt = '0;
              state_nxt    = START;
            end else begin
              beat_cnt_nxt = beat_cnt + 1'b1;
            end
          end
        end
      end

      START: begin
        cls_start_nxt = 1'b1;
        state_nxt     = WAIT;
      end

      WAIT: begin
        if (cls_done) begin
          result_nxt       = cls_digit;
          result_valid_nxt = 1'b1;
          state_nxt        = DONE;
        end else if (timer_expired) begin
          frame_error_nxt = 1'b1;
          state_nxt       = IDLE;
        end
      end

      DONE: begin
        // A new frame outranks the ack; the ack is absorbed either way.
        if (accept && host_sof) begin
          result_valid_nxt = 1'b0;
          pix_wr_en_nxt    = 1'b1;
          pix_addr_nxt     = '0;
          pix_data_nxt     = data_in;
          beat_cnt_nxt     = ADDR_W'(1);
          state_nxt        = LOAD;
        end else if (result_ack) begin
          result_valid_nxt = 1'b0;
          state_nxt        = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      pix_wr_en    <= 1'b0;
      pix_addr     <= '0;
      pix_data     <= '0;
      cls_start    <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      pix_wr_en    <= pix_wr_en_nxt;
      pix_addr     <= pix_addr_nxt;
      pix_data     <= pix_data_nxt;
      cls_start    <= cls_start_nxt;
      result_valid <= result_valid_nxt;
      result       <= result_nxt;
      frame_error  <= frame_error_nxt;
    end
  end

endmodule

// File: tb/tb_mnist_frame_controller.sv
// tb/tb_mnist_frame_controller.sv - self-checking bench for mnist_frame_controller
module tb_mnist_frame_controller;

  localparam int TO = 8;

  typedef struct packed {
    logic       v;
    logic       sof;
    logic [6:0] d;
    logic       ack;
    logic       done;
    logic [3:0] dig;
    logic       wr;
    logic [4:0] addr;
    logic       cs;
    logic       rv;
    logic [3:0] res;
    logic       err;
    logic       busy;
    logic       rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_valid = 1'b0;
  logic       host_sof = 1'b0;
  logic [6:0] data_in = '0;
  logic       result_ack = 1'b0;
  logic       cls_done = 1'b0;
  logic [3:0] cls_digit = '0;
  logic       host_ready;
  logic       pix_wr_en;
  logic [4:0] pix_addr;
  logic [6:0] pix_data;
  logic       cls_start;
  logic       result_valid;
  logic [3:0] result;
  logic       frame_error;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mnist_frame_controller #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .host_valid   (host_valid),
    .host_sof     (host_sof),
    .data_in      (data_in),
    .host_ready   (host_ready),
    .result_ack   (result_ack),
    .pix_wr_en    (pix_wr_en),
    .pix_addr     (pix_addr),
    .pix_data     (pix_data),
    .cls_start    (cls_start),
    .cls_done     (cls_done),
    .cls_digit    (cls_digit),
    .result_valid (result_valid),
    .result       (result),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic sof, input logic [6:0] d,
                       input logic ack, input logic done, input logic [3:0] dig);
    host_valid = v;
    host_sof   = sof;
    data_in    = d;
    result_ack = ack;
    cls_done   = done;
    cls_digit  = dig;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 4'd0);
    step();
  endtask

  // One accepted-or-dropped beat, checking the write it should (not) produce.
  task automatic beat(input string nm, input logic sof, input logic [6:0] d,
                      input logic exp_wr, input logic [4:0] exp_addr);
    drive(1'b1, sof, d, 1'b0, 1'b0, 4'd0);
    step();
    chk({nm, " wr"}, 32'(pix_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk({nm, " addr"}, 32'(pix_addr), 32'(exp_addr));
      chk({nm, " data"}, 32'(pix_data), 32'(d));
    end
  endtask

  // Beats from..27 of a frame already in LOAD, then the START->WAIT step.
  task automatic finish_frame(input string nm, input int from);
    for (int i = from; i < 28; i++) beat($sformatf("%s beat%0d", nm, i), 1'b0, 7'(i + 32), 1'b1, 5'(i));
    chk({nm, " start busy"}, 32'(busy), 32'd1);
    chk({nm, " start ready"}, 32'(host_ready), 32'd0);
    chk({nm, " no early cls_start"}, 32'(cls_start), 32'd0);
    idle_step();
    chk({nm, " cls_start"}, 32'(cls_start), 32'd1);
  endtask

  function automatic vec_t mk(input logic v, input logic sof, input logic [6:0] d,
                              input logic ack, input logic done, input logic [3:0] dig,
                              input logic wr, input logic [4:0] addr, input logic cs,
                              input logic rv, input logic [3:0] res, input logic err,
                              input logic bsy, input logic rdy);
    vec_t t;
    t.v = v; t.sof = sof; t.d = d; t.ack = ack; t.done = done; t.dig = dig;
    t.wr = wr; t.addr = addr; t.cs = cs; t.rv = rv; t.res = res;
    t.err = err; t.busy = bsy; t.rdy = rdy;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    // Main flow: idle, full frame, start pulse, WAIT 4 cycles, done on the 5th,
    // DONE hold, dropped beat, ack, dropped beat and stray cls_done in IDLE.
    tbl.push_back(mk(0, 0, 7'd0, 0, 0, 4'd0, 0, 5'd0, 0, 0, 4'd0, 0, 0, 1));
    for (int i = 0; i < 28; i++)
      tbl.push_back(mk(1, 1'(i == 0), 7'(i), 0, 0, 4'd0, 1, 5'(i), 0, 0, 4'd0, 0, 1, 1'(i != 27)));
    tbl.push_back(mk(0, 0, 7'd0, 0, 0, 4'd0, 0, 5'd0, 1, 0, 4'd0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 7'd0, 0, 0, 4'd0, 0, 5'd0, 0, 0, 4'd0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 7'd0, 0, 1, 4'd7, 0, 5'd0, 0, 1, 4'd7, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'd0, 0, 0, 4'd0, 0, 5'd0, 0, 1, 4'd7, 0, 0, 1));
    tbl.push_back(mk(1, 0, 7'd5, 0, 0, 4'd0, 0, 5'd0, 0, 1, 4'd7, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'd0, 1, 0, 4'd0, 0, 5'd0, 0, 0, 4'd0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 7'd9, 0, 0, 4'd0, 0, 5'd0, 0, 0, 4'd0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'd0, 0, 1, 4'd4, 0, 5'd0, 0, 0, 4'd0, 0, 0, 1));

    // Reset values, applied through an edge with reset_n low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr", 32'(pix_wr_en), 32'd0);
    chk("reset addr", 32'(pix_addr), 32'd0);
    chk("reset data", 32'(pix_data), 32'd0);
    chk("reset cls_start", 32'(cls_start), 32'd0);
    chk("reset rv", 32'(result_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset err", 32'(frame_error), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(host_ready), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].ack, tbl[i].done, tbl[i].dig);
      step();
      chk($sformatf("vec%0d wr", i), 32'(pix_wr_en), 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        chk($sformatf("vec%0d addr", i), 32'(pix_addr), 32'(tbl[i].addr));
        chk($sformatf("vec%0d data", i), 32'(pix_data), 32'(tbl[i].d));
      end
      chk($sformatf("vec%0d cls_start", i), 32'(cls_start), 32'(tbl[i].cs));
      chk($sformatf("vec%0d rv", i), 32'(result_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("vec%0d result", i), 32'(result), 32'(tbl[i].res));
      chk($sformatf("vec%0d err", i), 32'(frame_error), 32'(tbl[i].err));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d ready", i), 32'(host_ready), 32'(tbl[i].rdy));
    end

    // Restart mid-frame at beat_cnt=10, then timeout after TO WAIT cycles.
    beat("rs b0", 1'b1, 7'd100, 1'b1, 5'd0);
    for (int i = 1; i < 10; i++) beat($sformatf("rs b%0d", i), 1'b0, 7'(100 + i), 1'b1, 5'(i));
    chk("rs no err before", 32'(frame_error), 32'd0);
    beat("rs restart", 1'b1, 7'h40, 1'b1, 5'd0);
    chk("rs restart err", 32'(frame_error), 32'd1);
    beat("rs after", 1'b0, 7'h41, 1'b1, 5'd1);
    chk("rs err single pulse", 32'(frame_error), 32'd0);
    finish_frame("rs", 2);
    for (int i = 1; i < TO; i++) begin
      if (i == 3) drive(1'b1, 1'b1, 7'h22, 1'b0, 1'b0, 4'd0);
      else drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 4'd0);
      step();
      chk($sformatf("to wait%0d err", i), 32'(frame_error), 32'd0);
      chk($sformatf("to wait%0d busy", i), 32'(busy), 32'd1);
      chk($sformatf("to wait%0d wr", i), 32'(pix_wr_en), 32'd0);
    end
    idle_step();
    chk("to err", 32'(frame_error), 32'd1);
    chk("to rv", 32'(result_valid), 32'd0);
    chk("to busy", 32'(busy), 32'd0);
    chk("to ready", 32'(host_ready), 32'd1);
    idle_step();
    chk("to err cleared", 32'(frame_error), 32'd0);

    // Rerun: cls_done lands in the timeout cycle and wins; digit 12 kept as-is.
    beat("rr b0", 1'b1, 7'd32, 1'b1, 5'd0);
    finish_frame("rr", 1);
    for (int i = 1; i < TO; i++) idle_step();
    chk("rr still waiting", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 4'd12);
    step();
    chk("rr rv", 32'(result_valid), 32'd1);
    chk("rr result", 32'(result), 32'd12);
    chk("rr no err", 32'(frame_error), 32'd0);
    chk("rr busy", 32'(busy), 32'd0);
    idle_step();
    chk("rr no late err", 32'(frame_error), 32'd0);
    chk("rr rv held", 32'(result_valid), 32'd1);

    // DONE: sof beat together with result_ack -> LOAD, addr 0, result cleared.
    drive(1'b1, 1'b1, 7'h11, 1'b1, 1'b0, 4'd0);
    step();
    chk("da wr", 32'(pix_wr_en), 32'd1);
    chk("da addr", 32'(pix_addr), 32'd0);
    chk("da data", 32'(pix_data), 32'h11);
    chk("da rv", 32'(result_valid), 32'd0);
    chk("da busy", 32'(busy), 32'd1);
    chk("da ready", 32'(host_ready), 32'd1);
    drive(1'b1, 1'b0, 7'h12, 1'b0, 1'b1, 4'd9);
    step();
    chk("da b1 addr", 32'(pix_addr), 32'd1);
    chk("da stray done ignored", 32'(result_valid), 32'd0);
    finish_frame("da", 2);
    idle_step();
    idle_step();

    // Asynchronous reset in the middle of WAIT.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar wr", 32'(pix_wr_en), 32'd0);
    chk("ar addr", 32'(pix_addr), 32'd0);
    chk("ar data", 32'(pix_data), 32'd0);
    chk("ar cls_start", 32'(cls_start), 32'd0);
    chk("ar rv", 32'(result_valid), 32'd0);
    chk("ar result", 32'(result), 32'd0);
    chk("ar err", 32'(frame_error), 32'd0);
    chk("ar busy", 32'(busy), 32'd0);
    chk("ar ready", 32'(host_ready), 32'd1);
    step();
    reset_n = 1'b1;
    idle_step();
    chk("ar idle busy", 32'(busy), 32'd0);
    chk("ar idle err", 32'(frame_error), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
